// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined MIPS core: BranchType codes, the bubble
// instruction word and the fetch FSM state constants.
package cpu_pkg;

   localparam logic [1:0] BT_BEQ = 2'b00;
   localparam logic [1:0] BT_BLE = 2'b01;
   localparam logic [1:0] BT_BLT = 2'b10;
   localparam logic [1:0] BT_BNE = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // DRAIN: a redirect arrived while a fetch was still outstanding
   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

endpackage

// File: rtl/branch_cond.sv
// Evaluates the branch condition from BranchType and the ALU flags of (rs - rt).
module branch_cond
   import cpu_pkg::*;
(
   input  logic [1:0] branch_type,
   input  logic       zero,
   input  logic       neg,
   output logic       cond
);

   // NOTE: default assignment first so every path drives cond and no latch is inferred.
   always_comb begin
      cond = 1'b0;
      case (branch_type)
         BT_BEQ:  cond = zero;
         BT_BLE:  cond = neg | zero;
         BT_BLT:  cond = neg;
         BT_BNE:  cond = ~zero;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request handshake, branch/jump
// redirect and the IF/ID pipeline register with stall and flush.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_i,
   input  logic [1:0]  branch_type_i,
   input  logic        alu_zero_i,
   input  logic        alu_neg_i,
   input  logic [31:0] branch_target_i,
   output logic        branch_taken_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc4_o,
   output logic        ifid_valid_o
);

   logic [31:0] pc;
   logic [31:0] redir_pc;
   logic [0:0]  state;
   logic [31:0] pc4;
   logic        cond;
   logic        jump_eff;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        accept;

   branch_cond u_branch_cond (
      .branch_type (branch_type_i),
      .zero        (alu_zero_i),
      .neg         (alu_neg_i),
      .cond        (cond)
   );

   // A stalled ID re-presents its jump, so only an unstalled jump redirects.
   assign branch_taken_o  = branch_i & cond;
   assign jump_eff        = jump_i & ~stall_i;
   assign redirect        = branch_taken_o | jump_eff;
   assign redirect_target = branch_taken_o ? branch_target_i : jump_target_i;

   assign pc4         = pc + 32'd4;
   assign imem_req_o  = ~rst_i;
   assign imem_addr_o = pc;
   assign accept      = imem_req_o & imem_ready_i & ~stall_i & ~redirect & (state == FETCH);

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc           <= RESET_PC;
         redir_pc     <= RESET_PC;
         state        <= FETCH;
         ifid_valid_o <= 1'b0;
         ifid_instr_o <= NOP_INSTR;
         ifid_pc4_o   <= 32'h0000_0000;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  ifid_valid_o <= 1'b0;
                  ifid_instr_o <= NOP_INSTR;
                  if (imem_ready_i) begin
                     pc <= redirect_target;
                  end else begin
                     // Address must stay at the old pc until its response arrives.
                     redir_pc <= redirect_target;
                     state    <= DRAIN;
                  end
               end else if (accept) begin
                  ifid_valid_o <= 1'b1;
                  ifid_instr_o <= imem_data_i;
                  ifid_pc4_o   <= pc4;
                  pc           <= pc4;
               end
            end
            DRAIN: begin
               if (imem_ready_i) begin
                  pc    <= redirect ? redirect_target : redir_pc;
                  state <= FETCH;
               end else if (redirect) begin
                  redir_pc <= redirect_target;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted imem responses, a queue of
// expected IF/ID entries, and per-feature scenario tasks.
module tb_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_data_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic        branch_i;
   logic [1:0]  branch_type_i;
   logic        alu_zero_i;
   logic        alu_neg_i;
   logic [31:0] branch_target_i;
   logic        branch_taken_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   ifid_t sb_q[$];

   always #5 clk_i = ~clk_i;

   fetch_unit dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .stall_i         (stall_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ready_i    (imem_ready_i),
      .imem_data_i     (imem_data_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_i        (branch_i),
      .branch_type_i   (branch_type_i),
      .alu_zero_i      (alu_zero_i),
      .alu_neg_i       (alu_neg_i),
      .branch_target_i (branch_target_i),
      .branch_taken_o  (branch_taken_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_pc4_o      (ifid_pc4_o),
      .ifid_valid_o    (ifid_valid_o)
   );

   // One clock cycle: check request/address/taken before the edge, push the
   // expected IF/ID entry if this cycle should accept, and pop/compare after.
   task automatic tick(input string name, input logic [31:0] exp_addr,
                       input bit exp_accept, input bit exp_taken);
      ifid_t exp;
      #1;
      n_cmp++;
      if (imem_req_o !== 1'b1) begin
         n_err++;
         $display("FAIL %s req: got %b want 1", name, imem_req_o);
      end
      n_cmp++;
      if (imem_addr_o !== exp_addr) begin
         n_err++;
         $display("FAIL %s addr: got %h want %h", name, imem_addr_o, exp_addr);
      end
      n_cmp++;
      if (branch_taken_o !== exp_taken) begin
         n_err++;
         $display("FAIL %s taken: got %b want %b", name, branch_taken_o, exp_taken);
      end
      if (exp_accept) sb_q.push_back('{instr: imem_data_i, pc4: exp_addr + 32'd4});
      @(posedge clk_i);
      #1;
      if (exp_accept) begin
         exp = sb_q.pop_front();
         n_cmp++;
         if (ifid_valid_o !== 1'b1 || ifid_instr_o !== exp.instr || ifid_pc4_o !== exp.pc4) begin
            n_err++;
            $display("FAIL %s ifid: got v=%b %h/%h want v=1 %h/%h", name,
                     ifid_valid_o, ifid_instr_o, ifid_pc4_o, exp.instr, exp.pc4);
         end
      end
   endtask

   task automatic expect_flushed(input string name);
      n_cmp++;
      if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin
         n_err++;
         $display("FAIL %s flush: got v=%b instr=%h want v=0 instr=0", name, ifid_valid_o, ifid_instr_o);
      end
   endtask

   task automatic clear_ctrl();
      stall_i = 0; jump_i = 0; jump_target_i = 0; branch_i = 0;
      branch_type_i = 2'b00; alu_zero_i = 0; alu_neg_i = 0; branch_target_i = 0;
   endtask

   task automatic test_reset();
      rst_i = 1; imem_ready_i = 0; imem_data_i = 0;
      clear_ctrl();
      repeat (2) @(posedge clk_i);
      #1;
      n_cmp++;
      if (imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset req: got %b want 0", imem_req_o);
      end
      n_cmp++;
      if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset ifid: got v=%b %h/%h want v=0 0/0", ifid_valid_o, ifid_instr_o, ifid_pc4_o);
      end
      n_cmp++;
      if (imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset addr: got %h want 0", imem_addr_o);
      end
      rst_i = 0;
   endtask

   task automatic test_sequential();
      imem_ready_i = 1;
      imem_data_i = 32'h2008_0001;
      tick("seq0", 32'h0, 1, 0);
      imem_data_i = 32'h2009_0002;
      tick("seq1", 32'h4, 1, 0);
   endtask

   task automatic test_stall();
      stall_i = 1; imem_data_i = 32'h8C0A_0000;
      tick("stall0", 32'h8, 0, 0);
      tick("stall1", 32'h8, 0, 0);
      n_cmp++;
      if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h2009_0002 || ifid_pc4_o !== 32'h8) begin
         n_err++;
         $display("FAIL stall hold: got v=%b %h/%h want v=1 20090002/8", ifid_valid_o, ifid_instr_o, ifid_pc4_o);
      end
      stall_i = 0;
      tick("stall_rel", 32'h8, 1, 0);
   endtask

   task automatic test_branch_cond();
      branch_i = 1; branch_type_i = 2'b11; alu_zero_i = 0; alu_neg_i = 0;
      branch_target_i = 32'h40; imem_data_i = 32'h1111_1111;
      tick("bne", 32'hC, 0, 1);
      expect_flushed("bne");
      branch_type_i = 2'b00; branch_target_i = 32'h999; imem_data_i = 32'h2222_2222;
      tick("beq_nt", 32'h40, 1, 0);
      branch_type_i = 2'b01; alu_zero_i = 1; branch_target_i = 32'h80;
      tick("ble", 32'h44, 0, 1);
      expect_flushed("ble");
      branch_type_i = 2'b10; branch_target_i = 32'h500; imem_data_i = 32'h2323_2323;
      tick("blt_nt", 32'h80, 1, 0);
      clear_ctrl();
   endtask

   task automatic test_jump_drain();
      imem_ready_i = 0; jump_i = 1; jump_target_i = 32'h100;
      tick("jmp", 32'h84, 0, 0);
      expect_flushed("jmp");
      jump_i = 0;
      tick("drain0", 32'h84, 0, 0);
      tick("drain1", 32'h84, 0, 0);
      imem_ready_i = 1; imem_data_i = 32'hDEAD_BEEF;
      tick("drain_done", 32'h84, 0, 0);
      expect_flushed("drain_done");
      imem_data_i = 32'h3333_3333;
      tick("jmp_tgt", 32'h100, 1, 0);
      stall_i = 1; jump_i = 1; jump_target_i = 32'h700;
      tick("jmp_stall", 32'h104, 0, 0);
      n_cmp++;
      if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h104) begin
         n_err++;
         $display("FAIL jmp_stall ifid: got v=%b pc4=%h want v=1 pc4=104", ifid_valid_o, ifid_pc4_o);
      end
      clear_ctrl();
      imem_data_i = 32'h3434_3434;
      tick("after_stall", 32'h104, 1, 0);
   endtask

   task automatic test_branch_jump();
      branch_i = 1; branch_type_i = 2'b00; alu_zero_i = 1; branch_target_i = 32'h200;
      jump_i = 1; jump_target_i = 32'h300;
      tick("br_jmp", 32'h108, 0, 1);
      clear_ctrl();
      imem_data_i = 32'h3535_3535;
      tick("br_win", 32'h200, 1, 0);
   endtask

   task automatic test_wrap();
      branch_i = 1; branch_type_i = 2'b11; alu_zero_i = 0; branch_target_i = 32'hFFFF_FFFC;
      tick("to_top", 32'h204, 0, 1);
      clear_ctrl();
      imem_data_i = 32'h4444_4444;
      tick("wrap", 32'hFFFF_FFFC, 1, 0);
      imem_data_i = 32'h4545_4545;
      tick("wrap0", 32'h0, 1, 0);
   endtask

   task automatic test_reset_in_drain();
      imem_ready_i = 0; jump_i = 1; jump_target_i = 32'h300;
      tick("jmp2", 32'h4, 0, 0);
      jump_i = 0;
      tick("drain_r", 32'h4, 0, 0);
      rst_i = 1; imem_ready_i = 1; imem_data_i = 32'hBAD0_BAD0;
      @(posedge clk_i);
      #1;
      n_cmp++;
      if (imem_req_o !== 1'b0 || ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL rst_drain: got req=%b v=%b addr=%h want req=0 v=0 addr=0",
                  imem_req_o, ifid_valid_o, imem_addr_o);
      end
      rst_i = 0; imem_data_i = 32'h5555_5555;
      tick("post_rst", 32'h0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch_cond();
      test_jump_drain();
      test_branch_jump();
      test_wrap();
      test_reset_in_drain();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
